// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding 64-bit load/store memory target with programmable wait states
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d, err_q, err_d;
  logic        commit, err;
  logic [63:0] offset;
  logic [IW-1:0] idx;
  logic [63:0] mem [DEPTH_WORDS];
  assign offset = addr_q - BASE_ADDR;
  assign idx = offset[IW+2:3];
  assign err = (addr_q[2:0] != 3'd0) || ((offset >> 3) >= 64'(DEPTH_WORDS));
  assign req_ready = reset && state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d = err_q;
    commit = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        write_d = req_write;
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        cnt_d = 4'(WAIT_CYCLES);
        state_d = WAIT;
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        commit = 1'b1;
        rdata_d = (write_q || err) ? 64'd0 : mem[idx];
        err_d = err;
        state_d = RESP;
      end
      RESP: if (resp_ready) begin
        rdata_d = 64'd0;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= 64'd0;
      write_q <= 1'b0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      rdata_q <= 64'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // reset outranks a commit landing on the same edge
  always_ff @(posedge clk)
    if (reset && commit && write_q && !err)
      for (int i = 0; i < 8; i++)
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Multi-cycle data-memory responder: the target end of the CPU load/store path.
- Accepts one 64-bit load or store request at a time over a valid/ready handshake and performs it after a configurable number of wait states.
- Returns read data or an error status over a second valid/ready handshake.
- Replaces the zero-latency data memory so the core and future bus masters can be verified against realistic memory latency and backpressure.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 64-bit words stored.
- BASE_ADDR, 64'h0: byte address of word 0.
- WAIT_CYCLES, 2: extra cycles between acceptance and commit; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- req_wstrb  input  8  byte enables; bit i covers wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  64  load data; 0 for stores and for errors.
- resp_err  output  1  misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, write, wdata and wstrb, load cnt=WAIT_CYCLES, and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, commit and go to RESP.
- Commit:
  - offset = addr - BASE_ADDR (64-bit wrap arithmetic); index = offset>>3.
  - err = (addr[2:0]!=0) or (index >= DEPTH_WORDS).
  - If err: no memory change; rdata=0.
  - Store without err: write only the strobed bytes of mem[index]. rdata=0.
  - Load without err: rdata = mem[index] as it stands at commit.
  - wstrb is ignored for loads; a store with wstrb=0 is legal and leaves memory unchanged.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE.
- Only one transaction is outstanding. Requests are never accepted in WAIT or RESP. req_* inputs are ignored outside the IDLE acceptance cycle.
- Memory array is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: req_ready=0 while reset is asserted, and 1 in the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0.
- Acceptance at rising edge N: WAIT is entered at N, commit happens at edge N+WAIT_CYCLES+1, and resp_valid=1 from that edge on.
- Latency from accept to resp_valid is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 the latency is 1 cycle.
- Response handshake completes at the edge where resp_valid&resp_ready=1.
  - resp_valid drops and req_ready rises after that edge.
  - The next request can be accepted at the following edge, giving a minimum issue interval of WAIT_CYCLES+3 cycles.
- resp_ready held high in advance: the response completes on its first valid cycle.
- resp_ready held low: RESP persists indefinitely, with outputs unchanged.
- Reset during WAIT (before commit): the transaction is dropped and no memory write occurs.
- Reset in the commit cycle: reset wins and no write occurs.
- Reset during RESP: the response is discarded.
- Writes to memory occur only on the commit edge.

## Test plan
- Store addr=0x10, wdata=0x1122334455667788, wstrb=0xFF; then load addr=0x10 -> resp_rdata=0x1122334455667788, resp_err=0, resp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
- Store addr=0x10, wdata=0xAAAA..., wstrb=0x0F over the previous value; load -> 0x11223344AAAAAAAA.
- Load addr=0x13 and store addr=0x14 -> resp_err=1, resp_rdata=0; a subsequent load of 0x10 shows memory unchanged.
- Load addr=BASE_ADDR+8*DEPTH_WORDS -> resp_err=1. Load addr=BASE_ADDR-8 -> resp_err=1.
- Hold resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_rdata are stable and req_ready=0 throughout. Release -> IDLE on the next edge, with req_ready=1 one cycle later.
- Assert reset for one cycle during WAIT of a store to 0x20 -> resp_valid never rises. A later load of 0x20 returns the pre-store value, and req_ready=1 in the cycle after reset is released.
